irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Prioritised interrupt controller sitting beside the single-cycle CPU (datapath + control unit).
- Collects edge-triggered requests from peripherals and masks them.
- Selects one interrupt and hands the CPU a jump vector through a req/ack handshake.
- Blocks further interrupts until the CPU signals return-from-interrupt. Non-nested: one level of service.

Parameters:
- N_IRQ, 4, number of interrupt lines; index 0 has highest priority.
- PC_W, 10, width of the program-counter vector.
- VEC_BASE, 10'h3F0, vector address of IRQ 0.
- VEC_STRIDE, 4, address distance between consecutive vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- irq  in  N_IRQ  peripheral request lines, rising-edge sensitive, synchronous to clk.
- we_mask  in  1  CPU write strobe for the mask register.
- mask_in  in  N_IRQ  new mask value; 1 = enabled.
- int_ack  in  1  CPU has taken the interrupt (PC pushed, jumped to vector) this cycle.
- reti  in  1  CPU executing return-from-interrupt this cycle.
- int_req  out  1  interrupt request to CPU control unit.
- vector  out  PC_W  jump target for the selected interrupt.
- irq_id  out  clog2(N_IRQ)  index of the selected/in-service interrupt.
- in_service  out  1  high while a handler is running.
- pending  out  N_IRQ  pending register, for CPU readback.
- mask  out  N_IRQ  mask register, for CPU readback.

Behaviour:
- Reset, sampled when reset=0 at a clk edge, sets: pending=0, mask=0, irq_prev=0, state=IDLE, int_req=0, in_service=0, irq_id=0, vector=VEC_BASE. Reset mid-REQ or mid-SERVICE aborts unconditionally.
- Edge detect:
  - irq_prev<=irq every cycle.
  - At any edge where irq[i]=1 and irq_prev[i]=0, pending[i] is set.
  - Level held high produces exactly one pending set.
- Mask: on we_mask=1, mask<=mask_in at that edge. Masked bits still latch into pending but are not eligible.
- Eligible set = pending & mask. Winner = lowest eligible index.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible≠0 at an edge, latch irq_id<=winner and vector<=VEC_BASE+winner*VEC_STRIDE (mod 2^PC_W); go to REQ.
  - REQ: int_req=1. Selection is frozen: a higher-priority arrival, mask change, or clearing of the mask bit does not change irq_id/vector. On int_ack=1: clear pending[irq_id], go to SERVICE.
  - SERVICE: in_service=1, int_req=0. On reti=1, go to IDLE. A new pending request can be accepted in the cycle after return.
- Outputs int_req and in_service are decoded from the registered state (no combinational input-to-output paths).
- Latency: irq rises before edge E0 → pending set at E0 → REQ at E1 → int_req visible after E1 (2 edges). int_ack at edge → int_req low next cycle.
- Simultaneous events:
  - Rising edge on irq[irq_id] in the same cycle as int_ack: set wins, pending stays 1 (new request).
  - we_mask together with the IDLE→REQ decision: the old mask value is used for that decision.
- Ignored inputs: int_ack outside REQ; reti outside SERVICE.
- irq_id and vector hold their value through SERVICE and after return, until the next selection.

Test Plan:
- Reset with all inputs toggling → all outputs at reset values; vector=0x3F0; reset released → no int_req.
- mask=4'b1111; pulse irq[2] → int_req high 2 edges later, vector=0x3F8, irq_id=2; int_ack → pending=0, in_service=1; reti → IDLE.
- mask=4'b1111; irq[3] and irq[1] rise together → irq_id=1, vector=0x3F4. After ack+reti → irq_id=3, vector=0x3FC.
- mask=4'b0000; pulse irq[0] → pending[0]=1, no int_req. Write mask=4'b0001 → int_req high, vector=0x3F0.
- In REQ for irq 2, raise irq[0] → vector stays 0x3F8 until ack. After reti → irq 0 served.
- Re-trigger irq[irq_id] in the same cycle as int_ack → pending bit remains 1 and is re-served after reti. Assert reset during SERVICE → in_service=0, pending=0 next cycle.

Source files
------------

// File: rtl/irq_controller.sv
// Prioritised, non-nesting interrupt controller: edge-latched pending bits, mask,
// lowest-index-wins selection and a req/ack/reti handshake with the CPU control unit.
//
// state   | meaning
// IDLE    | no interrupt outstanding; waiting for an eligible pending bit
// REQ     | int_req asserted; irq_id/vector frozen until the CPU acks
// SERVICE | handler running; further requests held off until reti
module irq_controller #(
    parameter int              N_IRQ      = 4,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3F0,
    parameter int              VEC_STRIDE = 4,
    localparam int             ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             we_mask,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic             int_ack,
    input  logic             reti,
    output logic             int_req,
    output logic [PC_W-1:0]  vector,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_nxt;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic [ID_W-1:0]  winner;
    logic             take;

    assign rise     = irq & ~irq_prev;
    assign eligible = pending & mask;
    assign take     = (state == IDLE) && (eligible != '0);

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        clr = '0;
        if (state == REQ && int_ack) clr[irq_id] = 1'b1;
    end

    // A fresh rising edge in the ack cycle re-arms the bit being cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= irq;
            pending  <= (pending & ~clr) | rise;
            if (we_mask) mask <= mask_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_id <= '0;
            vector <= VEC_BASE;
        end else if (take) begin
            irq_id <= winner;
            vector <= VEC_BASE + PC_W'(VEC_STRIDE * int'(winner));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take)    state_nxt = REQ;
            REQ:     if (int_ack) state_nxt = SERVICE;
            SERVICE: if (reti)    state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        int_req    = 1'b0;
        in_service = 1'b0;
        case (state)
            REQ:     int_req    = 1'b1;
            SERVICE: in_service = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a transaction-level model queues each expected
// grant; a monitor pops and compares whenever int_req rises.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       we_mask;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       reti;
    logic       int_req;
    logic [9:0] vector;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] mask;

    always #5 clk = ~clk;

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .we_mask    (we_mask),
        .mask_in    (mask_in),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .vector     (vector),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] vec;
    } grant_t;

    grant_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;

    // Reference model: mode 0 = nothing outstanding, 1 = requesting, 2 = in handler.
    logic [3:0] m_pend, m_mask, m_prev;
    logic [1:0] m_id;
    logic [9:0] m_vec;
    int         m_mode;
    logic       req_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_mask = '0;
        m_prev = '0;
        m_mode = 0;
        m_id   = '0;
        m_vec  = 10'h3F0;
    endtask

    task automatic model_step(input logic [3:0] i_irq, input logic i_we, input logic [3:0] i_mi,
                              input logic i_ack, input logic i_reti, input logic i_rst);
        logic [3:0] rises;
        logic [3:0] elig;
        int         k;
        grant_t     g;
        if (!i_rst) begin
            model_reset();
            return;
        end
        rises = i_irq & ~m_prev;
        elig  = m_pend & m_mask;
        if (m_mode == 0) begin
            if (elig != 4'b0) begin
                k = 0;
                while (!elig[k]) k++;
                m_id   = 2'(k);
                m_vec  = 10'((32'h3F0 + 4 * k) % 1024);
                g.id   = m_id;
                g.vec  = m_vec;
                exp_q.push_back(g);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (i_ack) begin
                m_pend[m_id] = 1'b0;
                m_mode       = 2;
            end
        end else begin
            if (i_reti) m_mode = 0;
        end
        m_pend = m_pend | rises;
        if (i_we) m_mask = i_mi;
        m_prev = i_irq;
    endtask

    task automatic check_state();
        chk("int_req",    int_req,    (m_mode == 1));
        chk("in_service", in_service, (m_mode == 2));
        chk("pending",    pending,    m_pend);
        chk("mask",       mask,       m_mask);
        chk("irq_id",     irq_id,     m_id);
        chk("vector",     vector,     m_vec);
    endtask

    task automatic cycle(input logic [3:0] i_irq, input logic i_we, input logic [3:0] i_mi,
                         input logic i_ack, input logic i_reti, input logic i_rst);
        @(negedge clk);
        check_state();
        irq     = i_irq;
        we_mask = i_we;
        mask_in = i_mi;
        int_ack = i_ack;
        reti    = i_reti;
        reset   = i_rst;
        model_step(i_irq, i_we, i_mi, i_ack, i_reti, i_rst);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every new request presented to the CPU must match the next queued grant.
    always @(negedge clk) begin
        grant_t g;
        if (int_req === 1'b1 && !req_seen) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL grant_unexpected: got irq_id %0d vector %0h expected no request",
                         irq_id, vector);
            end else begin
                g = exp_q.pop_front();
                chk("grant_id",  irq_id, g.id);
                chk("grant_vec", vector, g.vec);
            end
        end
        req_seen = (int_req === 1'b1);
    end

    initial begin
        logic [3:0] r_irq;
        reset   = 1'b0;
        irq     = '0;
        we_mask = 1'b0;
        mask_in = '0;
        int_ack = 1'b0;
        reti    = 1'b0;
        model_reset();

        for (int j = 0; j < 4; j++)
            cycle(4'($urandom), 1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0);
        idle(3);

        // Single request on irq 2.
        cycle(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        idle(2);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // irq 3 and irq 1 together: 1 first, then 3.
        cycle(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        idle(3);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Masked request becomes eligible once unmasked.
        cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Higher-priority arrival and mask clear while requesting do not move the selection.
        cycle(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(2);
        cycle(4'b0001, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
        idle(2);
        cycle(4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
        idle(1);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        idle(3);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Re-trigger in the ack cycle, then reset during service.
        cycle(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        idle(3);
        cycle(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomised traffic.
        r_irq = '0;
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] flip;
            logic       w, a, rt, rs;
            flip = '0;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
            r_irq = r_irq ^ flip;
            w  = ($urandom_range(0, 15) == 0);
            a  = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            rt = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 199) != 0);
            cycle(r_irq, w, 4'($urandom), a, rt, rs);
        end

        idle(4);
        @(negedge clk);
        chk("grant_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
